wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Register-file write-back arbiter for a single write port shared between a
//   single-cycle ALU and a load path. Loads are parked in a 2-entry FIFO; the
//   ALU normally wins, but a starvation counter forces the FIFO head through
//   after three consecutive ALU wins while loads are waiting. A pending-load
//   scoreboard (x1..x31) tracks registers with an outstanding load so decode
//   can query hazards.
//
// Ports
//   clk                     : sole clock, rising edge
//   reset                   : asynchronous, active-high
//   alu_valid/rd/data       : ALU result, accepted on alu_valid & alu_ready
//   alu_ready               : ALU result accepted this cycle
//   mem_valid/rd/data       : load result, accepted on mem_valid & mem_ready
//   mem_ready               : load FIFO not full
//   iss_valid/iss_rd        : decode issued a load targeting iss_rd
//   chk_rs1/2, chk_busy1/2  : scoreboard hazard query (combinational)
//   wen/wreg/wdata          : registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  input  logic [4:0]        chk_rs1,
  input  logic [4:0]        chk_rs2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              wen,
  output logic [4:0]        wreg,
  output logic [DATA_W-1:0] wdata
);

  // Saturating 2-bit increment for the starvation counter.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  // Load FIFO state
  logic [1:0]        cnt_q, cnt_d;
  logic              wptr_q, rptr_q;
  logic [4:0]        fifo_rd_q   [2];
  logic [DATA_W-1:0] fifo_data_q [2];

  logic [1:0]        starve_q, starve_d;
  logic [31:1]       pend_q, pend_d;

  logic              wen_q, wen_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              fifo_nempty;
  logic              alu_win, fifo_win, push;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;
  logic [31:0]       pend_full, set_vec, clr_vec, pend_next;

  // ---- Stage: winner selection and next-state (all from registered state) ----
  always_comb begin
    fifo_nempty = (cnt_q != 2'd0);
    mem_ready   = (cnt_q < 2'd2);
    // Once starved for three cycles the FIFO head is forced through.
    alu_ready   = !((starve_q == 2'd3) && fifo_nempty);

    alu_win   = alu_valid && alu_ready;
    fifo_win  = !alu_win && fifo_nempty;
    push      = mem_valid && mem_ready;
    head_rd   = fifo_rd_q[rptr_q];
    head_data = fifo_data_q[rptr_q];

    cnt_d = cnt_q;
    unique case ({push, fifo_win})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    starve_d = starve_q;
    if (!fifo_nempty || fifo_win) starve_d = 2'd0;
    else if (alu_win)             starve_d = sat_inc2(starve_q);

    // Bit 0 of the widened vector is constant 0 so x0 is never busy.
    pend_full = {pend_q, 1'b0};
    set_vec   = (iss_valid && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
    clr_vec   = (fifo_win && (head_rd != 5'd0)) ? (32'd1 << head_rd) : 32'd0;
    // Set applied after clear so a same-cycle re-issue keeps the bit.
    pend_next = (pend_full & ~clr_vec) | set_vec;
    pend_d    = pend_next[31:1];

    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (alu_win) begin
      wen_d   = (alu_rd != 5'd0);
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end else if (fifo_win) begin
      wen_d   = (head_rd != 5'd0);
      wreg_d  = head_rd;
      wdata_d = head_data;
    end

    chk_busy1 = pend_full[chk_rs1];
    chk_busy2 = pend_full[chk_rs2];
  end

  // ---- Stage: registered control, scoreboard and write port ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      starve_q <= 2'd0;
      pend_q   <= '0;
      wen_q    <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      if (push)     wptr_q <= ~wptr_q;
      if (fifo_win) rptr_q <= ~rptr_q;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      wen_q    <= wen_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // FIFO payload needs no reset: validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= mem_rd;
      fifo_data_q[wptr_q] <= mem_data;
    end
  end

  assign wen   = wen_q;
  assign wreg  = wreg_q;
  assign wdata = wdata_q;

endmodule
